sensor_bcd_latch: RTL and testbench

SENSOR_BCD_LATCH -- requirements
Module: sensor_bcd_latch

---
 rtl/sensor_bcd_latch.sv | 173 +++++++++++++++++
 tb/tb_sensor_bcd_latch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_bcd_latch.sv
// Latches validated DHT11 readings and converts them to BCD tens/units digits.
// Optional feature macro: DECIMAL_ROUND_EN (round integers up when decimal >= 5).
module sensor_bcd_latch #(
  parameter int unsigned STALE_CYCLES = 5000000
) (
  input  logic        clk_1MHz,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [39:0] frame_data,
  output logic        busy,
  output logic [3:0]  humidity10,
  output logic [3:0]  humidity0,
  output logic [3:0]  temperature10,
  output logic [3:0]  temperature0,
  output logic        reading_valid,
  output logic        frame_err,
  output logic [7:0]  err_count,
  output logic        stale
);

  localparam int unsigned CW = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES) : 1;
  localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, CONV, UPDATE} state_t;

  state_t          state_q, state_d;
  logic [39:0]     frame_q, frame_d;
  logic [1:0][19:0] dd_q, dd_d, dd_step;
  logic [2:0]      iter_q, iter_d;
  logic [3:0]      hum10_q, hum10_d, hum0_q, hum0_d;
  logic [3:0]      temp10_q, temp10_d, temp0_q, temp0_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      errcnt_q, errcnt_d;
  logic            stale_q, stale_d;
  logic [CW-1:0]   stale_cnt_q, stale_cnt_d;

  logic [7:0] hum_int, hum_dec, temp_int, temp_dec, checksum, sum8;
  logic [8:0] hum_adj, temp_adj;
  logic       frame_ok;

  assign hum_int  = frame_q[39:32];
  assign hum_dec  = frame_q[31:24];
  assign temp_int = frame_q[23:16];
  assign temp_dec = frame_q[15:8];
  assign checksum = frame_q[7:0];

  // Checksum always covers the raw bytes; 8-bit sum wraps mod 256.
  assign sum8 = hum_int + hum_dec + temp_int + temp_dec;

`ifdef DECIMAL_ROUND_EN
  assign hum_adj  = {1'b0, hum_int}  + ((hum_dec  >= 8'd5) ? 9'd1 : 9'd0);
  assign temp_adj = {1'b0, temp_int} + ((temp_dec >= 8'd5) ? 9'd1 : 9'd0);
`else
  assign hum_adj  = {1'b0, hum_int};
  assign temp_adj = {1'b0, temp_int};
`endif

  assign frame_ok = (sum8 == checksum) && (hum_adj <= 9'd99) && (temp_adj <= 9'd99);

  // One double-dabble step per channel: {hundreds, tens, units, binary}.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dd
    logic [19:0] adj;
    always_comb begin
      adj = dd_q[gi];
      for (int k = 0; k < 3; k++) begin
        if (adj[8+4*k +: 4] >= 4'd5) begin
          adj[8+4*k +: 4] = adj[8+4*k +: 4] + 4'd3;
        end
      end
    end
    assign dd_step[gi] = {adj[18:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    dd_d        = dd_q;
    iter_d      = iter_q;
    hum10_d     = hum10_q;
    hum0_d      = hum0_q;
    temp10_d    = temp10_q;
    temp0_d     = temp0_q;
    valid_d     = valid_q;
    ferr_d      = 1'b0;
    errcnt_d    = errcnt_q;
    stale_cnt_d = (stale_cnt_q == STALE_MAX) ? stale_cnt_q : stale_cnt_q + CW'(1);
    stale_d     = stale_q | (stale_cnt_q == STALE_MAX);

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          frame_d = frame_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (frame_ok) begin
          dd_d[0] = {12'd0, hum_adj[7:0]};
          dd_d[1] = {12'd0, temp_adj[7:0]};
          iter_d  = 3'd0;
          state_d = CONV;
        end else begin
          ferr_d   = 1'b1;
          errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;
          state_d  = IDLE;
        end
      end
      CONV: begin
        dd_d   = dd_step;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        // A fresh reading overrides a stale threshold hit on the same edge.
        hum10_d     = dd_q[0][15:12];
        hum0_d      = dd_q[0][11:8];
        temp10_d    = dd_q[1][15:12];
        temp0_d     = dd_q[1][11:8];
        valid_d     = 1'b1;
        stale_d     = 1'b0;
        stale_cnt_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      dd_q        <= '0;
      iter_q      <= '0;
      hum10_q     <= '0;
      hum0_q      <= '0;
      temp10_q    <= '0;
      temp0_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      errcnt_q    <= '0;
      stale_q     <= 1'b0;
      stale_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      dd_q        <= dd_d;
      iter_q      <= iter_d;
      hum10_q     <= hum10_d;
      hum0_q      <= hum0_d;
      temp10_q    <= temp10_d;
      temp0_q     <= temp0_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      errcnt_q    <= errcnt_d;
      stale_q     <= stale_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign humidity10    = hum10_q;
  assign humidity0     = hum0_q;
  assign temperature10 = temp10_q;
  assign temperature0  = temp0_q;
  assign reading_valid = valid_q;
  assign frame_err     = ferr_q;
  assign err_count     = errcnt_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_sensor_bcd_latch.sv
// Self-checking bench for sensor_bcd_latch: vector table, hand sequences, random frames.
module tb_sensor_bcd_latch;

  localparam int unsigned STALE = 100;

  logic        clk_1MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [39:0] frame_data = '0;
  logic        busy, reading_valid, frame_err, stale;
  logic [3:0]  humidity10, humidity0, temperature10, temperature0;
  logic [7:0]  err_count;

  sensor_bcd_latch #(.STALE_CYCLES(STALE)) dut (
    .clk_1MHz      (clk_1MHz),
    .rst_n         (rst_n),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .busy          (busy),
    .humidity10    (humidity10),
    .humidity0     (humidity0),
    .temperature10 (temperature10),
    .temperature0  (temperature0),
    .reading_valid (reading_valid),
    .frame_err     (frame_err),
    .err_count     (err_count),
    .stale         (stale)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct {
    logic [39:0] data;
    bit          ok;
    logic [3:0]  h10, h0, t10, t0;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_h10 = 0, exp_h0 = 0, exp_t10 = 0, exp_t0 = 0;
  int exp_err = 0;
  bit exp_rv = 0;

  task automatic tick();
    @(posedge clk_1MHz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_digits(input string name);
    chk({name, "_h10"}, 32'(humidity10), 32'(exp_h10));
    chk({name, "_h0"},  32'(humidity0),  32'(exp_h0));
    chk({name, "_t10"}, 32'(temperature10), 32'(exp_t10));
    chk({name, "_t0"},  32'(temperature0),  32'(exp_t0));
  endtask

  // Reference rules: raw-byte checksum mod 256, optional rounding, both integers <= 99.
  function automatic void model(input logic [39:0] d, output bit ok, output int hv, output int tv);
    int hi, hd, ti, td, cs;
    hi = int'(d[39:32]); hd = int'(d[31:24]);
    ti = int'(d[23:16]); td = int'(d[15:8]); cs = int'(d[7:0]);
`ifdef DECIMAL_ROUND_EN
    if (hd >= 5) hi = hi + 1;
    if (td >= 5) ti = ti + 1;
`endif
    ok = (((hd + int'(d[39:32]) + td + int'(d[23:16])) % 256) == cs) && (hi <= 99) && (ti <= 99);
    hv = hi;
    tv = ti;
  endfunction

  // Drives one frame starting at the next edge (edge 0) and follows it to completion.
  task automatic apply_frame(input string tag, input logic [39:0] d, input bit ok,
                             input int h10, input int h0, input int t10, input int t0);
    frame_data = d;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    chk({tag, "_ferr_e0"}, 32'(frame_err), 32'd0);
    tick();
    chk({tag, "_ferr_e1"}, 32'(frame_err), ok ? 32'd0 : 32'd1);
    if (!ok) begin
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      chk({tag, "_errcnt"}, 32'(err_count), 32'(exp_err));
      chk({tag, "_busy_rej"}, 32'(busy), 32'd0);
      chk_digits({tag, "_rej"});
    end else begin
      for (int e = 2; e <= 9; e++) begin
        tick();
        chk({tag, "_busy_conv"}, 32'(busy), 32'd1);
        chk({tag, "_ferr_conv"}, 32'(frame_err), 32'd0);
      end
      chk_digits({tag, "_e9_hold"});
      tick();
      exp_h10 = h10; exp_h0 = h0; exp_t10 = t10; exp_t0 = t0; exp_rv = 1;
      chk_digits({tag, "_e10"});
      chk({tag, "_rv"}, 32'(reading_valid), 32'(exp_rv));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_stale_upd"}, 32'(stale), 32'd0);
      chk({tag, "_errcnt"}, 32'(err_count), 32'(exp_err));
    end
    $display("txn %s data=%010h ok=%0d digits=%0d%0d/%0d%0d err_count=%0d",
             tag, d, ok, humidity10, humidity0, temperature10, temperature0, err_count);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{40'h37_00_18_00_4F, 1'b1, 4'd5, 4'd5, 4'd2, 4'd4};
    vecs[1] = '{40'h37_00_18_00_50, 1'b0, 4'd5, 4'd5, 4'd2, 4'd4};
`ifdef DECIMAL_ROUND_EN
    vecs[2] = '{40'h37_06_18_04_59, 1'b1, 4'd5, 4'd6, 4'd2, 4'd4};
`else
    vecs[2] = '{40'h37_06_18_04_59, 1'b1, 4'd5, 4'd5, 4'd2, 4'd4};
`endif
    vecs[3] = '{40'h64_00_18_00_7C, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[4] = '{40'h00_00_00_00_00, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[5] = '{40'h63_00_63_00_C6, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
    vecs[6] = '{40'h05_00_64_00_69, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
`ifdef DECIMAL_ROUND_EN
    vecs[7] = '{40'h63_05_0A_04_76, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0};
    vecs[8] = '{40'h50_FF_30_10_8F, 1'b1, 4'd8, 4'd1, 4'd4, 4'd9};
`else
    vecs[7] = '{40'h63_05_0A_04_76, 1'b1, 4'd9, 4'd9, 4'd1, 4'd0};
    vecs[8] = '{40'h50_FF_30_10_8F, 1'b1, 4'd8, 4'd0, 4'd4, 4'd8};
`endif

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rv", 32'(reading_valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    chk_digits("rst");

    // First table frame arrives on the very first edge with rst_n high
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      apply_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].ok,
                  vecs[i].h10, vecs[i].h0, vecs[i].t10, vecs[i].t0);
      tick();
    end

    // Second frame_valid during conversion must be dropped entirely
    frame_data = 40'h0C_00_22_00_2E;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    chk("ign_ferr_e1", 32'(frame_err), 32'd0);
    tick();
    frame_data = 40'h37_00_18_00_50;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("ign_busy_e3", 32'(busy), 32'd1);
    for (int e = 4; e <= 9; e++) begin
      tick();
      chk("ign_ferr_conv", 32'(frame_err), 32'd0);
    end
    chk_digits("ign_e9_hold");
    tick();
    exp_h10 = 1; exp_h0 = 2; exp_t10 = 3; exp_t0 = 4;
    chk_digits("ign_e10");
    chk("ign_busy_done", 32'(busy), 32'd0);
    tick();
    chk("ign_busy_after", 32'(busy), 32'd0);
    chk("ign_ferr_after", 32'(frame_err), 32'd0);
    chk("ign_errcnt", 32'(err_count), 32'(exp_err));
    $display("txn ignore_during_conv digits=%0d%0d/%0d%0d err_count=%0d",
             humidity10, humidity0, temperature10, temperature0, err_count);

    // Stale timing, including UPDATE landing on the threshold edge
    apply_frame("stale_a", 40'h37_00_18_00_4F, 1'b1, 5, 5, 2, 4);
    repeat (89) tick();
    apply_frame("stale_coincide", 40'h0C_00_22_00_2E, 1'b1, 1, 2, 3, 4);
    repeat (99) tick();
    chk("stale_99", 32'(stale), 32'd0);
    tick();
    chk("stale_100", 32'(stale), 32'd1);
    repeat (5) tick();
    chk("stale_hold", 32'(stale), 32'd1);
    $display("txn stale_threshold stale=%0d", stale);
    apply_frame("stale_clear", 40'h37_00_18_00_4F, 1'b1, 5, 5, 2, 4);

    // Randomized frames against the reference rules
    for (int n = 0; n < 40; n++) begin
      logic [39:0] d;
      bit ok;
      int hv, tv;
      if ($urandom_range(0, 1) == 1) begin
        int hi, hd, ti, td;
        hi = $urandom_range(0, 110); hd = $urandom_range(0, 9);
        ti = $urandom_range(0, 110); td = $urandom_range(0, 9);
        d = {8'(hi), 8'(hd), 8'(ti), 8'(td), 8'((hi + hd + ti + td) % 256)};
      end else begin
        d = {8'($urandom), 32'($urandom)};
      end
      model(d, ok, hv, tv);
      apply_frame($sformatf("rnd%0d", n), d, ok, hv / 10, hv % 10, tv / 10, tv % 10);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Error counter saturation
    for (int n = 0; n < 256; n++) begin
      apply_frame($sformatf("sat%0d", n), 40'h64_00_18_00_7C, 1'b0, 0, 0, 0, 0);
    end
    chk("err_sat", 32'(err_count), 32'd255);

    // Reset at edge 5 aborts a conversion that also saw a dropped frame_valid
    frame_data = 40'h2D_00_0B_00_38;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    tick();
    frame_data = 40'h0C_00_22_00_2E;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_h10 = 0; exp_h0 = 0; exp_t10 = 0; exp_t0 = 0; exp_err = 0; exp_rv = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rv", 32'(reading_valid), 32'd0);
    chk("abort_ferr", 32'(frame_err), 32'd0);
    chk("abort_errcnt", 32'(err_count), 32'd0);
    chk("abort_stale", 32'(stale), 32'd0);
    chk_digits("abort");
    repeat (12) tick();
    chk("abort_busy_later", 32'(busy), 32'd0);
    chk_digits("abort_later");
    $display("txn reset_abort busy=%0d err_count=%0d", busy, err_count);
    apply_frame("post_abort", 40'h2D_00_0B_00_38, 1'b1, 4, 5, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
